// File: rtl/bus_write_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_write_responder
// Description : Grants the bus for each write request and closes the grant
//               window with a one-cycle write_ack after a programmable
//               latency. The FSM runs IDLE -> WAIT -> ACK -> GAP. Requests
//               that arrive while a window is open are queued, up to QDEPTH
//               of them, and served back to back. Each pair of windows is
//               separated by a single GAP cycle with bus_gnt low.
//
// Ports       : clock       - rising-edge clock for all state
//               reset       - synchronous, active-low reset
//               enable      - when low, all state and outputs are frozen and
//                             a write in that cycle is lost
//               write       - one-cycle request pulse; only a clean 1 counts
//               latency     - grant-to-ack delay in cycles, sampled when a
//                             window starts
//               bus_gnt     - high from grant through ack, inclusive
//               write_ack   - one-cycle pulse in the last cycle of a window
//               busy        - high whenever the FSM is not IDLE
//               pending_cnt - number of queued requests not yet granted
//               overflow    - sticky; a request arrived with the queue full
//               proto_err   - sticky; write was X/Z while enabled
//
// Revision    : 1.0 - initial release
// ============================================================================
module bus_write_responder #(
    parameter int LAT_W  = 4,
    parameter int QDEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             write,
    input  logic [LAT_W-1:0] latency,
    output logic             bus_gnt,
    output logic             write_ack,
    output logic             busy,
    output logic [3:0]       pending_cnt,
    output logic             overflow,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [3:0]       c_qdepth = 4'(QDEPTH);
    localparam logic [LAT_W-1:0] c_one    = LAT_W'(1);
    localparam logic [LAT_W-1:0] c_zero   = '0;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             perr_q, perr_d;
    logic             gnt_q, gnt_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;

    logic             w_write_valid;
    logic             w_write_unknown;
    logic             w_enqueue;
    logic             w_dequeue;

    // Only a clean logic 1 is a request. X/Z is flagged but never acted on.
    assign w_write_valid   = (write === 1'b1);
    assign w_write_unknown = $isunknown(write);

    // A request seen outside IDLE is queued. The GAP cycle pulls the next
    // queued request when there is one.
    assign w_enqueue = enable && w_write_valid && (state_q != S_IDLE);
    assign w_dequeue = enable && (state_q == S_GAP) && (pend_q != 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        perr_d  = perr_q;

        if (enable) begin
            if (w_write_unknown) begin
                perr_d = 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (w_write_valid) begin
                        // A zero latency goes straight to ACK, so grant and
                        // ack appear together in the first window cycle.
                        if (latency == c_zero) begin
                            state_d = S_ACK;
                            cnt_d   = c_zero;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = latency;
                        end
                    end
                end
                S_WAIT: begin
                    // The counter holds the cycles left before ack. Leaving
                    // on the final decrement puts ack exactly 'latency'
                    // cycles after the first grant cycle.
                    if (cnt_q <= c_one) begin
                        state_d = S_ACK;
                        cnt_d   = c_zero;
                    end else begin
                        cnt_d = cnt_q - c_one;
                    end
                end
                S_ACK: begin
                    state_d = S_GAP;
                end
                S_GAP: begin
                    if (pend_q != 4'd0) begin
                        if (latency == c_zero) begin
                            state_d = S_ACK;
                            cnt_d   = c_zero;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = latency;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // A dequeue frees the slot the coincident request takes, so a
            // write in a serving GAP cycle is net zero even with a full queue.
            if (w_enqueue && w_dequeue) begin
                pend_d = pend_q;
            end else if (w_enqueue) begin
                if (pend_q >= c_qdepth) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + 4'd1;
                end
            end else if (w_dequeue) begin
                pend_d = pend_q - 4'd1;
            end
        end
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they describe and are glitch-free.
    always_comb begin
        gnt_d  = (state_d == S_WAIT) || (state_d == S_ACK);
        ack_d  = (state_d == S_ACK);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            gnt_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign bus_gnt     = gnt_q;
    assign write_ack   = ack_q;
    assign busy        = busy_q;
    assign pending_cnt = pend_q;
    assign overflow    = ovf_q;
    assign proto_err   = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_write_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_write_responder
// Description : Table-driven bench for bus_write_responder. Each record holds
//               the inputs applied before one rising edge and the outputs
//               expected in the cycle that follows it. The X/Z request
//               sequence is hand-written and runs only on a 4-state simulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_write_responder;

    localparam int LAT_W  = 4;
    localparam int QDEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             write;
    logic [LAT_W-1:0] latency;
    logic             bus_gnt;
    logic             write_ack;
    logic             busy;
    logic [3:0]       pending_cnt;
    logic             overflow;
    logic             proto_err;

    always #5 clock = ~clock;

    bus_write_responder #(
        .LAT_W  (LAT_W),
        .QDEPTH (QDEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .write       (write),
        .latency     (latency),
        .bus_gnt     (bus_gnt),
        .write_ack   (write_ack),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .overflow    (overflow),
        .proto_err   (proto_err)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       wr;
        logic [3:0] lat;
        logic       gnt;
        logic       ack;
        logic       bsy;
        logic [3:0] pend;
        logic       ovf;
        logic       perr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic r, input logic e, input logic w,
                                input logic [3:0] l, input logic g,
                                input logic a, input logic b,
                                input logic [3:0] p, input logic o);
        vec_t v;
        v.rst_n = r;
        v.en    = e;
        v.wr    = w;
        v.lat   = l;
        v.gnt   = g;
        v.ack   = a;
        v.bsy   = b;
        v.pend  = p;
        v.ovf   = o;
        v.perr  = 1'b0;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic probe;
    logic four_state;

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        write   = 1'b0;
        latency = '0;

        // reset, including a write during reset that must be ignored
        add(0,1,0,4'd0, 0,0,0,4'd0,0);
        add(0,1,1,4'd3, 0,0,0,4'd0,0);

        // latency 3: grant cycles 1..4, ack cycle 4, gap 5, idle 6;
        // latency changes after the start and must not matter
        add(1,1,1,4'd3, 1,0,1,4'd0,0);
        add(1,1,0,4'd7, 1,0,1,4'd0,0);
        add(1,1,0,4'd7, 1,0,1,4'd0,0);
        add(1,1,0,4'd7, 1,1,1,4'd0,0);
        add(1,1,0,4'd7, 0,0,1,4'd0,0);
        add(1,1,0,4'd7, 0,0,0,4'd0,0);

        // latency 0: grant and ack together in cycle 1, gap cycle 2
        add(1,1,1,4'd0, 1,1,1,4'd0,0);
        add(1,1,0,4'd0, 0,0,1,4'd0,0);
        add(1,1,0,4'd0, 0,0,0,4'd0,0);

        // latency 1: write in the ack cycle queues, write in the serving
        // gap cycle is net zero
        add(1,1,1,4'd1, 1,0,1,4'd0,0);
        add(1,1,0,4'd1, 1,1,1,4'd0,0);
        add(1,1,1,4'd1, 0,0,1,4'd1,0);
        add(1,1,1,4'd1, 1,0,1,4'd1,0);
        add(1,1,0,4'd1, 1,1,1,4'd1,0);
        add(1,1,0,4'd1, 0,0,1,4'd1,0);
        add(1,1,0,4'd1, 1,0,1,4'd0,0);
        add(1,1,0,4'd1, 1,1,1,4'd0,0);
        add(1,1,0,4'd1, 0,0,1,4'd0,0);
        add(1,1,0,4'd1, 0,0,0,4'd0,0);

        // write while disabled in IDLE is lost
        add(1,0,1,4'd2, 0,0,0,4'd0,0);
        add(1,1,0,4'd2, 0,0,0,4'd0,0);

        // latency 2, enable low for edges 2..3 (with a lost write):
        // grant 1..5, ack cycle 5
        add(1,1,1,4'd2, 1,0,1,4'd0,0);
        add(1,1,0,4'd2, 1,0,1,4'd0,0);
        add(1,0,0,4'd2, 1,0,1,4'd0,0);
        add(1,0,1,4'd2, 1,0,1,4'd0,0);
        add(1,1,0,4'd2, 1,1,1,4'd0,0);
        add(1,1,0,4'd2, 0,0,1,4'd0,0);
        add(1,1,0,4'd2, 0,0,0,4'd0,0);

        // latency 5, six writes: queue fills to 4, sixth overflows in the
        // ack cycle, then four windows each followed by one gap cycle
        add(1,1,1,4'd5, 1,0,1,4'd0,0);
        for (int k = 1; k <= 4; k++) add(1,1,1,4'd5, 1,0,1,4'(k),0);
        add(1,1,1,4'd5, 1,1,1,4'd4,1);
        add(1,1,0,4'd5, 0,0,1,4'd4,1);
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < 6; j++) add(1,1,0,4'd5, 1,(j == 5),1,4'(3 - w),1);
            add(1,1,0,4'd5, 0,0,1,4'(3 - w),1);
        end
        add(1,1,0,4'd5, 0,0,0,4'd0,1);

        // latency 4: reset at edge 2 aborts the window and clears the queue
        // and the sticky overflow; no ack follows
        add(1,1,1,4'd4, 1,0,1,4'd0,1);
        add(1,1,1,4'd4, 1,0,1,4'd1,1);
        add(0,1,0,4'd4, 0,0,0,4'd0,0);
        for (int k = 0; k < 6; k++) add(1,1,0,4'd4, 0,0,0,4'd0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst_n;
            enable  = vecs[i].en;
            write   = vecs[i].wr;
            latency = vecs[i].lat;
            tick();
            check($sformatf("v%0d bus_gnt", i),     {3'b0, bus_gnt},   {3'b0, vecs[i].gnt});
            check($sformatf("v%0d write_ack", i),   {3'b0, write_ack}, {3'b0, vecs[i].ack});
            check($sformatf("v%0d busy", i),        {3'b0, busy},      {3'b0, vecs[i].bsy});
            check($sformatf("v%0d pending_cnt", i), pending_cnt,       vecs[i].pend);
            check($sformatf("v%0d overflow", i),    {3'b0, overflow},  {3'b0, vecs[i].ovf});
            check($sformatf("v%0d proto_err", i),   {3'b0, proto_err}, {3'b0, vecs[i].perr});
        end

        // X/Z request handling needs a simulator that keeps X values
        probe      = 1'bx;
        four_state = $isunknown(probe);
        if (four_state) begin
            reset   = 1'b1;
            latency = 4'd2;
            enable  = 1'b0;
            write   = 1'bx;
            tick();
            check("x_disabled proto_err", {3'b0, proto_err}, 4'd0);
            enable = 1'b1;
            write  = 1'bx;
            tick();
            check("x proto_err", {3'b0, proto_err}, 4'd1);
            check("x busy",      {3'b0, busy},      4'd0);
            check("x bus_gnt",   {3'b0, bus_gnt},   4'd0);
            write = 1'bz;
            tick();
            check("z proto_err", {3'b0, proto_err}, 4'd1);
            check("z busy",      {3'b0, busy},      4'd0);
            check("z bus_gnt",   {3'b0, bus_gnt},   4'd0);
            write = 1'b0;
            tick();
            check("sticky proto_err", {3'b0, proto_err}, 4'd1);
            reset = 1'b0;
            tick();
            check("reset proto_err", {3'b0, proto_err}, 4'd0);
            reset = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
